// File: rtl/ram_sp_arbiter.sv
// ram_sp_arbiter: shares one single-port async-read RAM between two requesters.
// After reset it sweeps INIT_VALUE into every location. It then grants one access
// per cycle, round-robin between port 0 and port 1.
module ram_sp_arbiter #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_write_en,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  typedef enum logic {
    ST_INIT,
    ST_SERVE
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] init_ptr;
  logic                  prio;  // port favoured when both request (0 or 1)
  logic                  rd_gnt0;
  logic                  rd_gnt1;

  // Grant decision: single requester wins outright, contention goes to prio.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == ST_SERVE) begin
      if (req0 && req1) begin
        gnt0 = ~prio;
        gnt1 = prio;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // RAM port mux: the INIT sweep, the granted port, or all-zero when idle.
  always_comb begin
    mem_address  = '0;
    mem_data_in  = '0;
    mem_write_en = 1'b0;
    if (state == ST_INIT) begin
      mem_write_en = 1'b1;
      mem_address  = init_ptr;
      mem_data_in  = INIT_VALUE;
    end else if (gnt0) begin
      mem_write_en = we0;
      mem_address  = addr0;
      mem_data_in  = wdata0;
    end else if (gnt1) begin
      mem_write_en = we1;
      mem_address  = addr1;
      mem_data_in  = wdata1;
    end
  end

  assign rd_gnt0 = gnt0 & ~we0;
  assign rd_gnt1 = gnt1 & ~we1;
  assign busy    = (state == ST_INIT);

  // Sequencer: INIT sweep, round-robin priority and registered read returns.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order within the block.
    if (reset) begin
      state    <= ST_INIT;
      init_ptr <= '0;
      prio     <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      rvalid0 <= rd_gnt0;
      rvalid1 <= rd_gnt1;
      if (rd_gnt0) rdata0 <= mem_data_out;
      if (rd_gnt1) rdata1 <= mem_data_out;

      case (state)
        ST_INIT: begin
          init_ptr <= init_ptr + 1'b1;
          if (init_ptr == '1) state <= ST_SERVE;
        end
        ST_SERVE: begin
          // The port just served drops to the back of the queue.
          if (gnt0)      prio <= 1'b1;
          else if (gnt1) prio <= 1'b0;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule
